// File: rtl/fft_sample_fetch.sv
// rtl/fft_sample_fetch.sv - FFT sample fetcher: address queue, in-order memory reads, sample FIFO.
// Optional BYTE_SWAP_EN reverses the bytes of each read word before it enters the FIFO.
module fft_sample_fetch #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AQ_D  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          calc_enable,
    output logic          calc_pause,
    input  logic [31:0]   calc_addr,
    input  logic          calc_addr_valid,
    input  logic          calc_done,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    input  logic          smp_ready,
    output logic          smp_last,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int QA = (AQ_D > 1) ? $clog2(AQ_D) : 1;
    localparam int QW = $clog2(AQ_D) + 1;
    localparam logic [QW-1:0] AQ_FULL = QW'(AQ_D);
    localparam logic [QW-1:0] AQ_HI   = QW'(AQ_D - 2);
    localparam logic [QA-1:0] AQ_LAST = QA'(AQ_D - 1);
    localparam logic [PW-1:0] F_FULL  = PW'(DEPTH);
    localparam logic [PW:0]   CREDITS = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [31:0]   aq_mem [AQ_D];
    logic [QA-1:0] aq_wr, aq_rd;
    logic [QW-1:0] aq_count;
    logic          aq_push, aq_pop, aq_full;

    logic [PW-1:0] outstanding;
    logic          rd_ok, credit_ok, done_seen, all_empty;

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] f_wr, f_rd, f_count;
    logic          f_push, f_pop, f_empty, f_full;
    logic [DW-1:0] f_wdata;

`ifdef BYTE_SWAP_EN
    if (DW % 8 != 0) begin : g_dw_check
        $error("BYTE_SWAP_EN needs DW to be a multiple of 8");
    end
    for (genvar i = 0; i < DW / 8; i++) begin : g_swap
        assign f_wdata[8*i +: 8] = mem_rdata[DW-8-8*i +: 8];
    end
`else
    assign f_wdata = mem_rdata;
`endif

    assign aq_full   = (aq_count == AQ_FULL);
    assign aq_pop    = mem_req & mem_gnt;
    assign aq_push   = calc_addr_valid & (!aq_full | aq_pop);
    // Credits count both reads in flight and words already buffered, so the FIFO cannot overflow.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, f_count}) < CREDITS;
    assign mem_req   = (aq_count != '0) & credit_ok;
    assign mem_addr  = (aq_count != '0) ? aq_mem[aq_rd] : '0;
    assign calc_pause = (aq_count >= AQ_HI) | (mem_req & !mem_gnt);

    assign rd_ok   = mem_rvalid & (outstanding != '0);
    assign f_count = f_wr - f_rd;
    assign f_empty = (f_count == '0);
    assign f_full  = (f_count == F_FULL);
    assign f_pop   = smp_valid & smp_ready;
    assign f_push  = rd_ok & (!f_full | f_pop);

    assign smp_valid = !f_empty;
    assign smp_data  = f_empty ? '0 : fifo_mem[f_rd[AW-1:0]];
    assign all_empty = (aq_count == '0) & (outstanding == '0) & f_empty;
    assign smp_last  = smp_valid & done_seen & (aq_count == '0) & (outstanding == '0)
                     & (f_count == PW'(1));

    assign busy        = (state != S_IDLE);
    assign calc_enable = (state == S_RUN);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (done_seen) state_nx = S_DRAIN;
            S_DRAIN: if ((f_pop & smp_last) | all_empty) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            done_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start)
                done_seen <= 1'b0;
            else if (state == S_RUN && calc_done)
                done_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aq_wr    <= '0;
            aq_rd    <= '0;
            aq_count <= '0;
            err      <= 1'b0;
        end else begin
            if (aq_push) aq_wr <= (aq_wr == AQ_LAST) ? '0 : aq_wr + 1'b1;
            if (aq_pop)  aq_rd <= (aq_rd == AQ_LAST) ? '0 : aq_rd + 1'b1;
            case ({aq_push, aq_pop})
                2'b10:   aq_count <= aq_count + 1'b1;
                2'b01:   aq_count <= aq_count - 1'b1;
                default: aq_count <= aq_count;
            endcase
            if (calc_addr_valid & aq_full & !aq_pop) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aq_push) aq_mem[aq_wr] <= calc_addr;
        if (f_push)  fifo_mem[f_wr[AW-1:0]] <= f_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            f_wr        <= '0;
            f_rd        <= '0;
        end else begin
            case ({aq_pop, rd_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (f_push) f_wr <= f_wr + 1'b1;
            if (f_pop)  f_rd <= f_rd + 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_sample_fetch.sv
// tb/tb_fft_sample_fetch.sv - directed bench for fft_sample_fetch with a 1-cycle memory and calculator model.
module tb_fft_sample_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        calc_addr_valid = 1'b0;
    logic        calc_done = 1'b0;
    logic [31:0] calc_addr = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        smp_ready = 1'b0;
    logic        busy, calc_enable, calc_pause, mem_req, smp_valid, smp_last, err;
    logic [31:0] mem_addr, smp_data;

    fft_sample_fetch #(.DW(32), .DEPTH(8), .AQ_D(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .calc_enable(calc_enable), .calc_pause(calc_pause),
        .calc_addr(calc_addr), .calc_addr_valid(calc_addr_valid), .calc_done(calc_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .smp_last(smp_last), .err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] addr_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] rx_data[$];
    logic        rx_last[$];
    logic [31:0] abase, dbase, resp_data;
    bit          gnt_en, ready_en, done_pending, resp_pending, stray_rvalid;
    bit          pause_prev, en_prev, valid_seen;
    int          first_valid_cyc, first_req_cyc, first_rx_cyc, last_rx_cyc, done_cyc;
`ifdef BYTE_SWAP_EN
    localparam logic [31:0] SWAP_EXP = 32'h44332211;
`else
    localparam logic [31:0] SWAP_EXP = 32'h11223344;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, observe 1ns later, well before the rising edge.
    task automatic tick(input bit st, input bit rs);
        @(negedge clk);
        rst        = rs;
        start      = st;
        mem_gnt    = gnt_en;
        smp_ready  = ready_en;
        mem_rvalid = resp_pending;
        mem_rdata  = resp_pending ? resp_data : 32'h0;
        if (stray_rvalid) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = 32'hBADBAD00;
            stray_rvalid = 1'b0;
        end
        calc_addr_valid = 1'b0;
        calc_done       = 1'b0;
        if (en_prev && !pause_prev) begin
            if (addr_q.size() > 0) begin
                calc_addr_valid = 1'b1;
                calc_addr       = addr_q.pop_front();
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end else if (done_pending) begin
                calc_done    = 1'b1;
                done_pending = 1'b0;
                done_cyc     = cyc;
            end
        end
        #1;
        resp_pending = mem_req && mem_gnt;
        if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (resp_pending) begin
            resp_data = dbase + ((mem_addr - abase) >> 2);
            gnt_log.push_back(mem_addr);
        end
        if (smp_valid) valid_seen = 1'b1;
        if (smp_valid && smp_ready) begin
            rx_data.push_back(smp_data);
            rx_last.push_back(smp_last);
            if (first_rx_cyc < 0) first_rx_cyc = cyc;
            last_rx_cyc = cyc;
        end
        pause_prev = calc_pause;
        en_prev    = calc_enable;
        cyc++;
    endtask

    task automatic new_run(input logic [31:0] ab, input int n, input logic [31:0] db);
        abase = ab;
        dbase = db;
        addr_q.delete();
        gnt_log.delete();
        rx_data.delete();
        rx_last.delete();
        for (int i = 0; i < n; i++) addr_q.push_back(ab + 32'(4 * i));
        done_pending    = 1'b1;
        valid_seen      = 1'b0;
        first_valid_cyc = -1;
        first_req_cyc   = -1;
        first_rx_cyc    = -1;
        last_rx_cyc     = -1;
        done_cyc        = -1;
        tick(1'b1, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick(1'b0, 1'b0);
            if (!busy) break;
        end
        check(tag, {31'b0, busy}, 32'h0);
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] ab,
                                input logic [31:0] db);
        logic [31:0] a, d;
        logic        l;
        check({tag, "_ngnt"}, 32'(gnt_log.size()), 32'(n));
        check({tag, "_nsmp"}, 32'(rx_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = (i < gnt_log.size()) ? gnt_log[i] : 32'hDEADDEAD;
            d = (i < rx_data.size()) ? rx_data[i] : 32'hDEADDEAD;
            l = (i < rx_last.size()) ? rx_last[i] : 1'bx;
            check($sformatf("%s_addr%0d", tag, i), a, ab + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), d, db + 32'(i));
            check($sformatf("%s_last%0d", tag, i), {31'b0, l}, {31'b0, (i == n - 1)});
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  {31'b0, busy},        32'h0);
        check({tag, "_en"},    {31'b0, calc_enable}, 32'h0);
        check({tag, "_pause"}, {31'b0, calc_pause},  32'h0);
        check({tag, "_req"},   {31'b0, mem_req},     32'h0);
        check({tag, "_addr"},  mem_addr,             32'h0);
        check({tag, "_valid"}, {31'b0, smp_valid},   32'h0);
        check({tag, "_data"},  smp_data,             32'h0);
        check({tag, "_last"},  {31'b0, smp_last},    32'h0);
        check({tag, "_err"},   {31'b0, err},         32'h0);
    endtask

    initial begin
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check_quiet("reset");

        // Basic 4-word run, memory always grants, consumer always ready.
        gnt_en = 1'b1;
        ready_en = 1'b1;
        new_run(32'h1000, 4, 32'hA0);
        tick(1'b0, 1'b0);
        check("basic_busy", {31'b0, busy}, 32'h1);
        wait_idle("basic_idle", 50);
        check_stream("basic", 4, 32'h1000, 32'hA0);
        check("basic_lat", 32'(first_req_cyc - first_valid_cyc), 32'd1);
        check("basic_tput", 32'(last_rx_cyc - first_rx_cyc), 32'd3);

        // Consumer stalled: credits stop issue after exactly 8 grants.
        ready_en = 1'b0;
        new_run(32'h2000, 16, 32'h200);
        repeat (40) tick(1'b0, 1'b0);
        check("bp_ngrants", 32'(gnt_log.size()), 32'd8);
        check("bp_req", {31'b0, mem_req}, 32'h0);
        check("bp_pause", {31'b0, calc_pause}, 32'h1);
        check("bp_valid", {31'b0, smp_valid}, 32'h1);
        check("bp_head", smp_data, 32'h200);
        ready_en = 1'b1;
        wait_idle("bp_idle", 200);
        check_stream("bp", 16, 32'h2000, 32'h200);
        check("bp_err", {31'b0, err}, 32'h0);

        // Memory stall: address must hold while the request waits.
        gnt_en = 1'b0;
        new_run(32'h3000, 4, 32'h300);
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0);
            if (mem_req) break;
        end
        check("stall_req", {31'b0, mem_req}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0);
            check($sformatf("stall_addr%0d", k), mem_addr, 32'h3000);
            check($sformatf("stall_pause%0d", k), {31'b0, calc_pause}, 32'h1);
        end
        gnt_en = 1'b1;
        wait_idle("stall_idle", 60);
        check_stream("stall", 4, 32'h3000, 32'h300);
        check("stall_err", {31'b0, err}, 32'h0);

        // Zero-length run.
        new_run(32'h5000, 0, 32'h0);
        tick(1'b0, 1'b0);
        check("zl_busy", {31'b0, busy}, 32'h1);
        wait_idle("zl_idle", 20);
        check("zl_time", {31'b0, (done_cyc >= 0) && ((cyc - 1 - done_cyc) <= 3)}, 32'h1);
        check("zl_valid", {31'b0, valid_seen}, 32'h0);
        check("zl_nsmp", 32'(rx_data.size()), 32'h0);

        new_run(32'h6000, 1, 32'h11223344);
        wait_idle("swap_idle", 30);
        check("swap_nsmp", 32'(rx_data.size()), 32'd1);
        check("swap_data", (rx_data.size() > 0) ? rx_data[0] : 32'hDEADDEAD, SWAP_EXP);

        // Reset in the middle of a run, then a stray read return must be ignored.
        ready_en = 1'b0;
        new_run(32'h7000, 8, 32'h700);
        repeat (6) tick(1'b0, 1'b0);
        check("mid_valid_pre", {31'b0, smp_valid}, 32'h1);
        addr_q.delete();
        done_pending = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check_quiet("midrst");
        stray_rvalid = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("stray_valid", {31'b0, smp_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
